eigen_herm_iter: RTL

EIGEN_HERM_ITER -- requirements
Module: eigen_herm_iter

---
 rtl/eigen_herm_pkg.sv | 30 +++
 rtl/eigen_herm_iter_sqrt.sv | 62 ++++++
 rtl/eigen_herm_iter.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/eigen_herm_pkg.sv
// Shared widths, latency and FSM encoding for the
// 2x2 Hermitian eigen-decomposition block.
package eigen_herm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MULT,
    SUM,
    SQRT,
    POST,
    OUT
  } state_t;

  function automatic int root_w(input int din_w);
    return din_w + 2;
  endfunction

  function automatic int disc_w(input int din_w);
    return 2 * din_w + 4;
  endfunction

  function automatic int lat(input int din_w);
    return root_w(din_w) + 4;
  endfunction

  localparam int ROOT_W = root_w(16);
  localparam int DISC_W = disc_w(16);
  localparam int LAT    = lat(16);

endpackage

// File: rtl/eigen_herm_iter_sqrt.sv
// Restoring integer square root, one result bit
// per cycle; root = floor(sqrt(rad)).
module iter_sqrt #(
  parameter int RAD_W = 36
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [RAD_W-1:0]   rad,
  output logic               busy,
  output logic               done,
  output logic [RAD_W/2-1:0] root
);

  localparam int RT_W  = RAD_W / 2;
  localparam int CNT_W = $clog2(RT_W + 1);

  logic [RAD_W-1:0] rad_q;
  logic [RT_W-1:0]  rem;
  logic [CNT_W-1:0] cnt;
  logic [RT_W+1:0]  cand;
  logic [RT_W+1:0]  sub;

  assign cand = {rem, rad_q[RAD_W-1 -: 2]};
  assign sub  = {root, 2'b01};

  // Load on start, then resolve one root bit per cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      busy  <= 1'b0;
      done  <= 1'b0;
      root  <= '0;
      rem   <= '0;
      rad_q <= '0;
      cnt   <= '0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        rad_q <= rad;
        rem   <= '0;
        root  <= '0;
        cnt   <= CNT_W'(RT_W);
        busy  <= 1'b1;
      end else if (busy) begin
        rad_q <= {rad_q[RAD_W-3:0], 2'b00};
        if (cand >= sub) begin
          rem  <= RT_W'(cand - sub);
          root <= {root[RT_W-2:0], 1'b1};
        end else begin
          rem  <= cand[RT_W-1:0];
          root <= {root[RT_W-2:0], 1'b0};
        end
        cnt <= cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/eigen_herm_iter.sv
// Eigenvalues / eigenvectors of a 2x2 Hermitian
// matrix [[r11, r12], [r12*, r22]], iterative root.
module eigen_herm_iter
  import eigen_herm_pkg::*;
#(
  parameter int DIN_WIDTH  = 16,
  parameter int DIN_POINT  = 15,
  parameter int DOUT_WIDTH = 16,
  parameter int DOUT_POINT = 13,
  parameter int COMPLEX    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DIN_WIDTH-1:0]  r11,
  input  logic [DIN_WIDTH-1:0]  r22,
  input  logic [DIN_WIDTH-1:0]  r12_re,
  input  logic [DIN_WIDTH-1:0]  r12_im,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic [DOUT_WIDTH-1:0] lamb1,
  output logic [DOUT_WIDTH-1:0] lamb2,
  output logic [DOUT_WIDTH-1:0] eigen1_y,
  output logic [DOUT_WIDTH-1:0] eigen2_y,
  output logic [DOUT_WIDTH-1:0] eigen_x_re,
  output logic [DOUT_WIDTH-1:0] eigen_x_im,
  output logic                  degen,
  output logic                  dout_valid,
  input  logic                  dout_ready
);

  localparam int RW = root_w(DIN_WIDTH);
  localparam int XW = disc_w(DIN_WIDTH);
  localparam int PW = 2 * DIN_WIDTH;
  localparam int DW = 2 * DIN_WIDTH + 2;
  localparam int W  = DIN_WIDTH + 4;
  localparam int UP = (DOUT_POINT > DIN_POINT) ?
                      DOUT_POINT - DIN_POINT : 0;
  localparam int DN = (DIN_POINT > DOUT_POINT) ?
                      DIN_POINT - DOUT_POINT : 0;
  localparam int IW = W + UP;
  localparam int CW = (IW > DOUT_WIDTH) ?
                      IW : DOUT_WIDTH + 1;

  // Rescale to the output point (floor) and clamp
  function automatic logic [DOUT_WIDTH-1:0] to_out(
    input logic signed [W-1:0] v
  );
    logic signed [CW-1:0] t;
    logic signed [CW-1:0] hi;
    logic signed [CW-1:0] lo;
    t  = CW'(v);
    t  = t <<< UP;
    t  = t >>> DN;
    hi = '0;
    hi[DOUT_WIDTH-2:0] = '1;
    lo = ~hi;
    if (t > hi)
      return hi[DOUT_WIDTH-1:0];
    else if (t < lo)
      return lo[DOUT_WIDTH-1:0];
    else
      return t[DOUT_WIDTH-1:0];
  endfunction

  state_t state;

  logic        [DIN_WIDTH-1:0] r11_q;
  logic        [DIN_WIDTH-1:0] r22_q;
  logic signed [DIN_WIDTH-1:0] re_q;
  logic signed [DIN_WIDTH-1:0] im_q;
  logic signed [DIN_WIDTH:0]   d_q;
  logic        [PW-1:0]        p_q;

  logic signed [DIN_WIDTH:0] d_next;
  logic signed [PW-1:0]      re_x;
  logic signed [PW-1:0]      im_x;
  logic        [PW-1:0]      p_next;
  logic signed [DW-1:0]      d_x;
  logic signed [DW-1:0]      d_sq;
  logic        [XW-1:0]      disc;

  logic          sq_start;
  logic          sq_busy;
  logic          sq_done;
  logic [RW-1:0] sq_root;

  logic signed [W-1:0] r11_w;
  logic signed [W-1:0] r22_w;
  logic signed [W-1:0] s_w;
  logic signed [W-1:0] tot;
  logic signed [W-1:0] l1;
  logic signed [W-1:0] l2;
  logic signed [W-1:0] e1;
  logic signed [W-1:0] e2;
  logic signed [W-1:0] xr_w;
  logic signed [W-1:0] xi_w;
  logic [DOUT_WIDTH-1:0] xr_o;
  logic [DOUT_WIDTH-1:0] xi_o;

  assign d_next = $signed({1'b0, r11_q})
                - $signed({1'b0, r22_q});
  assign re_x   = PW'(re_q);
  assign im_x   = PW'(im_q);
  assign p_next = $unsigned(re_x * re_x)
                + $unsigned(im_x * im_x);

  assign d_x  = DW'(d_q);
  assign d_sq = d_x * d_x;
  assign disc = {2'b00, $unsigned(d_sq)}
              + {2'b00, p_q, 2'b00};

  assign sq_start = (state == SUM);

  iter_sqrt #(
    .RAD_W (XW)
  ) u_sqrt (
    .clk   (clk),
    .rst   (rst),
    .start (sq_start),
    .rad   (disc),
    .busy  (sq_busy),
    .done  (sq_done),
    .root  (sq_root)
  );

  assign r11_w = $signed(W'(r11_q));
  assign r22_w = $signed(W'(r22_q));
  assign s_w   = $signed(W'(sq_root));
  assign tot   = r11_w + r22_w;
  assign l1    = (tot + s_w) >>> 1;
  assign l2    = (tot - s_w) >>> 1;
  assign e1    = l1 - r11_w;
  assign e2    = l2 - r11_w;
  assign xr_w  = W'(re_q);
  assign xi_w  = W'(im_q);
  assign xr_o  = to_out(xr_w);
  assign xi_o  = to_out(xi_w);

  // Control FSM with registered handshakes and results
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      din_ready  <= 1'b1;
      dout_valid <= 1'b0;
      lamb1      <= '0;
      lamb2      <= '0;
      eigen1_y   <= '0;
      eigen2_y   <= '0;
      eigen_x_re <= '0;
      eigen_x_im <= '0;
      degen      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (din_valid) begin
            r11_q     <= r11;
            r22_q     <= r22;
            re_q      <= r12_re;
            im_q      <= (COMPLEX != 0) ? r12_im : '0;
            din_ready <= 1'b0;
            state     <= MULT;
          end
        end
        MULT: begin
          d_q   <= d_next;
          p_q   <= p_next;
          state <= SUM;
        end
        SUM: state <= SQRT;
        SQRT: begin
          if (sq_done && !sq_busy)
            state <= POST;
        end
        POST: begin
          lamb1      <= to_out(l1);
          lamb2      <= to_out(l2);
          eigen1_y   <= to_out(e1);
          eigen2_y   <= to_out(e2);
          eigen_x_re <= xr_o;
          eigen_x_im <= xi_o;
          degen      <= (xr_o == '0) && (xi_o == '0);
          dout_valid <= 1'b1;
          state      <= OUT;
        end
        OUT: begin
          if (dout_ready) begin
            dout_valid <= 1'b0;
            din_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
